i2c_slave: RTL and testbench

I2C target (slave) that answers a single 7-bit address on a bus driven by an I2C master. It oversamples SCL/SDA on the system clock, detects START/STOP, ACKs matching writes and hands each received byte to the fabric. With reads compiled in, it also serves bytes from the fabric back to the master. It sits at the pad boundary opposite the team's I2C master and drives SDA open-drain only; it never drives SCL and never stretches the clock.

---
 rtl/i2c_slave.sv | 224 ++++++++++++++++++++++
 tb/tb_i2c_slave.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave.sv
// i2c_slave: I2C target answering a single 7-bit address. SCL/SDA are
// oversampled on clk; START/STOP are detected anywhere; matching writes are
// ACKed and each byte is handed to the fabric. SDA is driven open-drain only,
// SCL is never driven or stretched.
//
// Build option: define I2C_SLAVE_READ_EN to build the read path (RD/ACK_R,
// tx_req/tx_data). Without it, a matching read address is NACKed.
//
// Ports:
//   clk      system clock (>= 10x SCL)
//   reset    asynchronous active-low reset
//   scl_in   raw SCL pad level
//   sda_in   raw SDA pad level
//   sda_oe   1 pulls SDA low
//   rx_data  last received write byte
//   rx_valid one-cycle pulse when rx_data updates
//   tx_data  byte served on a read
//   tx_req   one-cycle pulse requesting the next tx_data
//   busy     addressed transfer in progress
//
// state        | meaning
// ST_IDLE      | waiting for START
// ST_ADDR      | shifting 7 address bits + R/W
// ST_ACK_A     | driving ACK for matching address
// ST_WR        | shifting a write byte
// ST_ACK_W     | driving ACK for a write byte
// ST_RD        | driving a read byte
// ST_ACK_R     | sampling master ACK/NACK
// ST_WAIT_STOP | ignoring the bus until START or STOP
module i2c_slave #(
  parameter logic [6:0] ADDR = 7'h50
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_req,
  output logic       busy
);

`ifdef I2C_SLAVE_READ_EN
  localparam bit READ_EN = 1'b1;
`else
  localparam bit READ_EN = 1'b0;
  logic unused_tx;
  assign unused_tx = ^tx_data;
`endif

  typedef enum logic [2:0] {
    ST_IDLE, ST_ADDR, ST_ACK_A, ST_WR, ST_ACK_W, ST_RD, ST_ACK_R, ST_WAIT_STOP
  } state_t;

  logic scl_s1, scl_s2, scl_h;
  logic sda_s1, sda_s2, sda_h;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      {scl_s1, scl_s2, scl_h} <= 3'b111;
      {sda_s1, sda_s2, sda_h} <= 3'b111;
    end else begin
      {scl_s1, scl_s2, scl_h} <= {scl_in, scl_s1, scl_s2};
      {sda_s1, sda_s2, sda_h} <= {sda_in, sda_s1, sda_s2};
    end
  end

  logic scl_rise, scl_fall, start_det, stop_det;
  assign scl_rise  = scl_s2 & ~scl_h;
  assign scl_fall  = ~scl_s2 & scl_h;
  assign start_det = scl_s2 & scl_h & sda_h & ~sda_s2;
  assign stop_det  = scl_s2 & scl_h & ~sda_h & sda_s2;

  state_t     state, state_nxt;
  logic [2:0] bit_cnt, bit_cnt_nxt;
  logic [7:0] shift, shift_nxt;
  logic [7:0] tx_shift, tx_shift_nxt;
  logic       byte_done, byte_done_nxt;   // 8th bit sampled, waiting for its SCL fall
  logic       rw, rw_nxt;
  logic       sda_oe_nxt, rx_valid_nxt, tx_req_nxt, busy_nxt;
  logic [7:0] rx_data_nxt;
  logic       addr_ok;

  assign addr_ok = (shift[7:1] == ADDR) && (!shift[0] || READ_EN);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      bit_cnt   <= 3'd7;
      shift     <= 8'h00;
      tx_shift  <= 8'h00;
      byte_done <= 1'b0;
      rw        <= 1'b0;
      sda_oe    <= 1'b0;
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      tx_req    <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      bit_cnt   <= bit_cnt_nxt;
      shift     <= shift_nxt;
      tx_shift  <= tx_shift_nxt;
      byte_done <= byte_done_nxt;
      rw        <= rw_nxt;
      sda_oe    <= sda_oe_nxt;
      rx_data   <= rx_data_nxt;
      rx_valid  <= rx_valid_nxt;
      tx_req    <= tx_req_nxt;
      busy      <= busy_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    bit_cnt_nxt   = bit_cnt;
    shift_nxt     = shift;
    tx_shift_nxt  = tx_shift;
    byte_done_nxt = byte_done;
    rw_nxt        = rw;
    sda_oe_nxt    = sda_oe;
    rx_data_nxt   = rx_data;
    rx_valid_nxt  = 1'b0;
    tx_req_nxt    = 1'b0;
    busy_nxt      = busy;

    if (stop_det) begin
      state_nxt     = ST_IDLE;
      sda_oe_nxt    = 1'b0;
      busy_nxt      = 1'b0;
      byte_done_nxt = 1'b0;
    end else if (start_det) begin
      state_nxt     = ST_ADDR;
      bit_cnt_nxt   = 3'd7;
      sda_oe_nxt    = 1'b0;
      busy_nxt      = 1'b0;
      byte_done_nxt = 1'b0;
    end else begin
      case (state)
        ST_IDLE: ;
        ST_ADDR, ST_WR: begin
          if (scl_rise) begin
            shift_nxt = {shift[6:0], sda_s2};
            if (bit_cnt == 3'd0) byte_done_nxt = 1'b1;
            else                 bit_cnt_nxt   = bit_cnt - 3'd1;
          end else if (scl_fall && byte_done) begin
            byte_done_nxt = 1'b0;
            if (state == ST_WR) begin
              state_nxt    = ST_ACK_W;
              sda_oe_nxt   = 1'b1;
              rx_data_nxt  = shift;
              rx_valid_nxt = 1'b1;
            end else if (addr_ok) begin
              state_nxt  = ST_ACK_A;
              sda_oe_nxt = 1'b1;
              busy_nxt   = 1'b1;
              rw_nxt     = shift[0];
              tx_req_nxt = shift[0] & READ_EN;
            end else begin
              state_nxt = ST_WAIT_STOP;
            end
          end
        end
        ST_ACK_A: begin
          if (scl_fall) begin
            bit_cnt_nxt = 3'd7;
            state_nxt   = ST_WR;
            sda_oe_nxt  = 1'b0;
`ifdef I2C_SLAVE_READ_EN
            if (rw) begin
              state_nxt    = ST_RD;
              tx_shift_nxt = tx_data;
              sda_oe_nxt   = ~tx_data[7];
            end
`endif
          end
        end
        ST_ACK_W: begin
          if (scl_fall) begin
            state_nxt   = ST_WR;
            bit_cnt_nxt = 3'd7;
            sda_oe_nxt  = 1'b0;
          end
        end
`ifdef I2C_SLAVE_READ_EN
        ST_RD: begin
          if (scl_fall) begin
            if (bit_cnt == 3'd0) begin
              state_nxt  = ST_ACK_R;
              sda_oe_nxt = 1'b0;
            end else begin
              bit_cnt_nxt  = bit_cnt - 3'd1;
              tx_shift_nxt = {tx_shift[6:0], 1'b0};
              sda_oe_nxt   = ~tx_shift[6];
            end
          end
        end
        ST_ACK_R: begin
          if (scl_rise) begin
            if (!sda_s2) begin
              tx_req_nxt    = 1'b1;
              byte_done_nxt = 1'b1;   // reused as "master ACKed"
            end else begin
              state_nxt = ST_WAIT_STOP;
              busy_nxt  = 1'b0;
            end
          end else if (scl_fall && byte_done) begin
            byte_done_nxt = 1'b0;
            state_nxt     = ST_RD;
            bit_cnt_nxt   = 3'd7;
            tx_shift_nxt  = tx_data;
            sda_oe_nxt    = ~tx_data[7];
          end
        end
`endif
        ST_WAIT_STOP: ;
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_slave.sv
module tb_i2c_slave;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       sda_line;
  logic       sda_oe, rx_valid, tx_req, busy;
  logic [7:0] rx_data;

  int total = 0;
  int bad = 0;
  int rx_cnt = 0;
  int tx_cnt = 0;
  int oe_cnt = 0;
  logic [7:0] exp_rx[$];
  logic [7:0] tx_q[$];
  logic [7:0] exp_rd[$];

  assign sda_line = sda_m & ~sda_oe;

  i2c_slave #(.ADDR(7'h50)) dut (
    .clk(clk), .reset(reset), .scl_in(scl_m), .sda_in(sda_line),
    .sda_oe(sda_oe), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_req(tx_req), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, o, e);
    end
  endtask

  // one clock, sampled on the falling edge; doubles as the output monitor
  task automatic tick();
    @(negedge clk);
    if (rx_valid) begin
      rx_cnt++;
      chk("rx_expected", 32'(exp_rx.size() != 0), 1);
      if (exp_rx.size() != 0) chk("rx_data", rx_data, exp_rx.pop_front());
    end
    if (tx_req) begin
      tx_cnt++;
      if (tx_q.size() != 0) begin
        tx_data = tx_q.pop_front();
        exp_rd.push_back(tx_data);
      end
    end
    if (sda_oe) oe_cnt++;
  endtask

  task automatic wait_q();
    repeat (5) tick();
  endtask

  task automatic start_c();
    sda_m = 1'b1; wait_q();
    scl_m = 1'b1; wait_q();
    sda_m = 1'b0; wait_q();
    scl_m = 1'b0; wait_q();
  endtask

  task automatic stop_c();
    sda_m = 1'b0; wait_q();
    scl_m = 1'b1; wait_q();
    sda_m = 1'b1; wait_q();
  endtask

  task automatic send_bit(input logic v);
    sda_m = v; wait_q();
    scl_m = 1'b1; wait_q();
    scl_m = 1'b0; wait_q();
  endtask

  // lat: check exact ACK-drive latency after the 8th bit; rel: check ACK release
  task automatic send_byte(input logic [7:0] b, input bit lat, input bit rel, output logic ack);
    for (int i = 7; i >= 1; i--) send_bit(b[i]);
    if (lat) begin
      sda_m = b[0]; wait_q();
      scl_m = 1'b1; wait_q();
      scl_m = 1'b0;
      tick(); tick();
      chk("ack_lat_early", sda_oe, 0);
      tick();
      chk("ack_lat", sda_oe, 1);
      tick(); tick();
    end else begin
      send_bit(b[0]);
    end
    sda_m = 1'b1; wait_q();
    scl_m = 1'b1; wait_q();
    ack = ~sda_line;
    scl_m = 1'b0; wait_q();
    if (rel) chk("ack_release", sda_oe, 0);
  endtask

  task automatic read_byte(input logic mack, output logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      sda_m = 1'b1; wait_q();
      scl_m = 1'b1; wait_q();
      b[i] = sda_line;
      scl_m = 1'b0; wait_q();
    end
    chk("rd_release", sda_oe, 0);
    sda_m = ~mack; wait_q();
    scl_m = 1'b1; wait_q();
    scl_m = 1'b0; wait_q();
  endtask

  initial begin
    logic       ack;
    logic [7:0] b;
    int r0, t0, o0;

    // reset values
    tick(); tick(); tick();
    chk("rst_sda_oe", sda_oe, 0);
    chk("rst_rx_data", rx_data, 8'h00);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_tx_req", tx_req, 0);
    chk("rst_busy", busy, 0);
    reset = 1'b1;
    wait_q();

    // write 0xAA to 0x50
    r0 = rx_cnt;
    exp_rx.push_back(8'hAA);
    start_c();
    send_byte(8'hA0, 1'b1, 1'b1, ack);
    chk("w1_ack_addr", ack, 1);
    chk("w1_busy", busy, 1);
    send_byte(8'hAA, 1'b0, 1'b1, ack);
    chk("w1_ack_data", ack, 1);
    stop_c();
    chk("w1_busy_after", busy, 0);
    chk("w1_rx_hold", rx_data, 8'hAA);
    chk("w1_rx_cnt", rx_cnt - r0, 1);

    // wrong address 0x51
    r0 = rx_cnt; o0 = oe_cnt;
    start_c();
    send_byte(8'hA2, 1'b0, 1'b0, ack);
    chk("w2_nack_addr", ack, 0);
    chk("w2_busy", busy, 0);
    send_byte(8'h12, 1'b0, 1'b0, ack);
    stop_c();
    chk("w2_oe_cycles", oe_cnt - o0, 0);
    chk("w2_rx_cnt", rx_cnt - r0, 0);
    chk("w2_busy_after", busy, 0);

    // read from 0x50
    t0 = tx_cnt;
    tx_q.push_back(8'h3C);
    tx_q.push_back(8'hC3);
    start_c();
    send_byte(8'hA1, 1'b0, 1'b0, ack);
`ifdef I2C_SLAVE_READ_EN
    chk("rd_ack_addr", ack, 1);
    read_byte(1'b1, b);
    chk("rd_q0", 32'(exp_rd.size() != 0), 1);
    if (exp_rd.size() != 0) chk("rd_byte0", b, exp_rd.pop_front());
    read_byte(1'b0, b);
    chk("rd_q1", 32'(exp_rd.size() != 0), 1);
    if (exp_rd.size() != 0) chk("rd_byte1", b, exp_rd.pop_front());
    chk("rd_busy_nack", busy, 0);
    stop_c();
    chk("rd_tx_req_cnt", tx_cnt - t0, 2);
`else
    chk("rd_nack_addr", ack, 0);
    stop_c();
    chk("rd_tx_req_cnt", tx_cnt - t0, 0);
`endif
    chk("rd_busy_after", busy, 0);
    tx_q.delete();

    // write, repeated START, write
    r0 = rx_cnt;
    exp_rx.push_back(8'h01);
    exp_rx.push_back(8'h02);
    start_c();
    send_byte(8'hA0, 1'b0, 1'b1, ack);
    chk("rs_ack1", ack, 1);
    send_byte(8'h01, 1'b0, 1'b1, ack);
    start_c();
    chk("rs_oe_after_start", sda_oe, 0);
    send_byte(8'hA0, 1'b0, 1'b1, ack);
    chk("rs_ack2", ack, 1);
    send_byte(8'h02, 1'b0, 1'b1, ack);
    stop_c();
    chk("rs_rx_cnt", rx_cnt - r0, 2);
    chk("rs_exp_empty", exp_rx.size(), 0);

    // async reset during the 4th data bit
    start_c();
    send_byte(8'hA0, 1'b0, 1'b1, ack);
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    sda_m = 1'b1; wait_q();
    scl_m = 1'b1; tick(); tick();
    chk("mr_busy_before", busy, 1);
    reset = 1'b0;
    #1;
    chk("mr_sda_oe", sda_oe, 0);
    chk("mr_busy", busy, 0);
    chk("mr_rx_data", rx_data, 8'h00);
    tick();
    reset = 1'b1;
    wait_q();
    scl_m = 1'b0; wait_q();
    stop_c();
    exp_rx.push_back(8'h55);
    start_c();
    send_byte(8'hA0, 1'b0, 1'b1, ack);
    send_byte(8'h55, 1'b0, 1'b1, ack);
    stop_c();
    chk("mr_rx_after", rx_data, 8'h55);
    chk("mr_exp_empty", exp_rx.size(), 0);

    // STOP in the middle of a byte
    r0 = rx_cnt;
    start_c();
    send_byte(8'hA0, 1'b0, 1'b1, ack);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    chk("ms_busy_before", busy, 1);
    stop_c();
    wait_q();
    chk("ms_rx_cnt", rx_cnt - r0, 0);
    chk("ms_busy", busy, 0);
    chk("ms_sda_oe", sda_oe, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
